// File: rtl/key_event_arbiter.sv
// Per-key press queue with round-robin serialisation onto a valid/ready event port.
// Optional per-key press counters: define KEY_ARB_PRESS_CNT_EN.
module key_event_arbiter #(
    parameter int N_KEYS = 4,
    parameter int CODE_W = 2,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_flag,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic [N_KEYS-1:0] pend,
    output logic              drop_pulse,
    output logic [DROP_W-1:0] drop_cnt
`ifdef KEY_ARB_PRESS_CNT_EN
    ,
    output logic [3*N_KEYS-1:0] press_cnt
`endif
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CODE_W-1:0] rr_ptr;
    logic [CODE_W-1:0] rr_d;
    logic [CODE_W-1:0] code_d;
    logic [CODE_W-1:0] gidx;
    logic              found;
    logic              valid_d;
    int                scan_j;
    logic [N_KEYS-1:0] grant_clr;
    logic [N_KEYS-1:0] drop_vec;
    logic [N_KEYS-1:0] pend_d;

    // First pending key at or after rr_ptr, wrapping past N_KEYS-1
    always_comb begin
        found  = 1'b0;
        gidx   = '0;
        scan_j = 0;
        for (int k = 0; k < N_KEYS; k++) begin
            scan_j = int'(rr_ptr) + k;
            if (scan_j >= N_KEYS) scan_j = scan_j - N_KEYS;
            if (!found && pend[scan_j]) begin
                found = 1'b1;
                gidx  = CODE_W'(scan_j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = evt_valid;
        code_d    = evt_code;
        rr_d      = rr_ptr;
        grant_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_clr[gidx] = 1'b1;
                    code_d          = gidx;
                    valid_d         = 1'b1;
                    state_d         = HOLD;
                end
            end
            HOLD: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    rr_d    = (evt_code == CODE_W'(N_KEYS - 1)) ?
                              '0 : evt_code + CODE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A press on a bit being granted this cycle re-arms it instead of dropping
    always_comb begin
        drop_vec = key_flag & pend & ~grant_clr;
        pend_d   = (pend & ~grant_clr) | key_flag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            rr_ptr    <= '0;
        end else begin
            state_q   <= state_d;
            evt_valid <= valid_d;
            evt_code  <= code_d;
            rr_ptr    <= rr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            pend       <= pend_d;
            drop_pulse <= |drop_vec;
            if (|drop_vec && drop_cnt != '1)
                drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

`ifdef KEY_ARB_PRESS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_cnt <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (key_flag[i] && !drop_vec[i])
                    press_cnt[3*i +: 3] <= press_cnt[3*i +: 3] + 3'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: expected codes queued at stimulus,
// popped on each handshake.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_flag;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic [3:0] pend;
    logic       drop_pulse;
    logic [7:0] drop_cnt;
`ifdef KEY_ARB_PRESS_CNT_EN
    logic [11:0] press_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int pulses;

    always #10 clk = ~clk;

    key_event_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_flag  (key_flag),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .pend      (pend),
        .drop_pulse(drop_pulse),
        .drop_cnt  (drop_cnt)
`ifdef KEY_ARB_PRESS_CNT_EN
        ,
        .press_cnt (press_cnt)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard side: every accepted event must match the queue head
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", 1, 0);
            end else begin
                check("evt_code", int'(evt_code), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_flag = k;
        tick();
        key_flag = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((evt_valid || pend != 0) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check("idle_timeout", 1, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_flag  = '0;
        evt_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_code", int'(evt_code), 0);
        rst_n = 1'b1;
        tick();

        // Single press, two-edge latency
        evt_ready = 1'b1;
        exp_q.push_back(1);
        press(4'b0010);
        check("t1_pend", int'(pend), 2);
        check("t1_valid_early", int'(evt_valid), 0);
        tick();
        check("t1_valid", int'(evt_valid), 1);
        check("t1_code", int'(evt_code), 1);
        check("t1_pend_clr", int'(pend), 0);
        tick();
        check("t1_valid_drop", int'(evt_valid), 0);

        // rr_ptr=2: key 3 wins, pointer wraps to 0
        exp_q.push_back(3);
        press(4'b1000);
        wait_idle();

        // Simultaneous presses from rr_ptr=0
        exp_q.push_back(0);
        exp_q.push_back(2);
        press(4'b0101);
        tick();
        check("t2_first", int'(evt_code), 0);
        check("t2_v1", int'(evt_valid), 1);
        tick();
        check("t2_gap", int'(evt_valid), 0);
        tick();
        check("t2_second", int'(evt_code), 2);
        check("t2_v2", int'(evt_valid), 1);
        wait_idle();
        check("t2_drops", int'(drop_cnt), 0);

        // Hold under backpressure; key 1 queued meanwhile
        evt_ready = 1'b0;
        exp_q.push_back(3);
        exp_q.push_back(1);
        press(4'b1000);
        tick();
        for (int c = 0; c < 10; c++) begin
            if (c == 4) key_flag = 4'b0010;
            tick();
            key_flag = '0;
            check("t3_hold_v", int'(evt_valid), 1);
            check("t3_hold_c", int'(evt_code), 3);
        end
        check("t3_pend", int'(pend), 2);
        evt_ready = 1'b1;
        wait_idle();

        // Repeated presses of a key in HOLD
        evt_ready = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(0);
        press(4'b0001);
        tick();
        check("t4_hold", int'(evt_code), 0);
        pulses = 0;
        press(4'b0001);
        check("t4_p1", int'(drop_pulse), 0);
        press(4'b0001);
        check("t4_p2", int'(drop_pulse), 1);
        pulses += int'(drop_pulse);
        tick();
        check("t4_gap", int'(drop_pulse), 0);
        press(4'b0001);
        check("t4_p3", int'(drop_pulse), 1);
        pulses += int'(drop_pulse);
        tick();
        check("t4_pulses", pulses, 2);
        check("t4_drop_cnt", int'(drop_cnt), 2);
        check("t4_pend", int'(pend), 1);
        evt_ready = 1'b1;
        wait_idle();

        // Set wins over grant-clear on the same bit
        exp_q.push_back(0);
        exp_q.push_back(0);
        press(4'b0001);
        press(4'b0001);
        check("sw_valid", int'(evt_valid), 1);
        check("sw_pend", int'(pend), 1);
        check("sw_pulse", int'(drop_pulse), 0);
        wait_idle();
        check("sw_drop_cnt", int'(drop_cnt), 2);

        // Asynchronous reset in HOLD
        evt_ready = 1'b0;
        press(4'b0100);
        tick();
        press(4'b1000);
        check("t5_pre", int'(pend), 8);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_valid", int'(evt_valid), 0);
        check("t5_pend", int'(pend), 0);
        check("t5_drop", int'(drop_cnt), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_after", int'(evt_valid), 0);

`ifdef KEY_ARB_PRESS_CNT_EN
        evt_ready = 1'b1;
        for (int p = 0; p < 9; p++) begin
            exp_q.push_back(2);
            press(4'b0100);
            wait_idle();
        end
        check("t6_cnt2", int'(press_cnt[8:6]), 1);
        check("t6_cnt0", int'(press_cnt[2:0]), 0);
        check("t6_cnt1", int'(press_cnt[5:3]), 0);
        check("t6_cnt3", int'(press_cnt[11:9]), 0);
`endif

        repeat (2) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
